// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller and its bench.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder; the only arithmetic in the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder stepped over WIDTH cycles, LSB first.
// Handshake: start is sampled only in IDLE; busy is high for the WIDTH RUN
// cycles; done is a one-cycle pulse with sum/cout/ovf already valid and held.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  fa_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          // carry_q is still the carry into the MSB on this last step
          sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed and random adds against an arithmetic model.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W       = 8;
  localparam int P       = 10;
  localparam int LAT     = (W + 1) * P;
  localparam int OP_SPAN = (W + 2) * P;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];
  time          exp_t_q[$];

  // clock / reset
  always #(P/2) clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic xc);
    logic [W:0]   t;
    logic [W-1:0] s;
    logic         v;
    t = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
    s = t[W-1:0];
    v = (xa[W-1] == xb[W-1]) && (s[W-1] != xa[W-1]);
    return {v, t[W], s};
  endfunction

  // scoreboard monitor
  logic [W+1:0] last_out = '0;
  int           busy_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cyc = 0;
      last_out = '0;
    end else begin
      check("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (busy) begin
        busy_cyc++;
        check("busy_has_op", 32'(exp_q.size() != 0), 32'd1);
      end
      if (done) begin
        check("done_has_op", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [W+1:0] e;
          time          et;
          e  = exp_q.pop_front();
          et = exp_t_q.pop_front();
          check("sum",          32'(sum),  32'(e[W-1:0]));
          check("cout",         32'(cout), 32'(e[W]));
          check("ovf",          32'(ovf),  32'(e[W+1]));
          check("done_latency", 32'($time), 32'(et));
          check("busy_cycles",  32'(busy_cyc), 32'(W));
        end
        busy_cyc = 0;
        last_out = {ovf, cout, sum};
      end else begin
        check("outputs_held", 32'({ovf, cout, sum}), 32'(last_out));
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    start = 1'b1;
    a     = xa;
    b     = xb;
    cin   = xc;
    exp_q.push_back(model(xa, xb, xc));
    exp_t_q.push_back($time + LAT);
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles at %0t", budget, $time);
    end
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    @(negedge clk);
    issue(xa, xb, xc);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom_range(0, 1));
    wait_done(W + 4);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_sum",   32'(sum),  32'd0);
    check("rst_cout",  32'(cout), 32'd0);
    check("rst_ovf",   32'(ovf),  32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    #2 rst_n = 1'b1;

    run_op(8'h3C, 8'h05, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1);

    // start held high across three back-to-back adds
    @(negedge clk);
    t0    = $time;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model(8'h01, 8'h01, 1'b1));
      exp_t_q.push_back(t0 + LAT + k * OP_SPAN);
    end
    for (int k = 0; k < 3; k++) wait_done(W + 4);
    start = 1'b0;
    @(negedge clk);

    // start held into RUN while operands wander
    @(negedge clk);
    issue(8'h5A, 8'h21, 1'b0);
    repeat (6) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    wait_done(W + 4);
    repeat (4) @(negedge clk);

    // reset in the middle of RUN
    @(negedge clk);
    issue(8'hA5, 8'h3C, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(sum),  32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf",  32'(ovf),  32'd0);
    exp_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(8'h12, 8'h34, 1'b0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
